// File: rtl/inport_fifo.sv
// Strobe-captured input port buffered in a DEPTH-entry FIFO, head word width-adapted onto BusMuxIn.
// Optional threshold interrupt: define INPORT_FIFO_IRQ_EN to register Irq, otherwise Irq is tied 0.
module inport_fifo #(
  parameter int DATA_WIDTH_IN  = 32,
  parameter int DATA_WIDTH_OUT = 32,
  parameter int DEPTH          = 4,
  parameter bit STROBE_EDGE    = 1'b1,
  parameter bit SIGN_EXT       = 1'b0,
  parameter int IRQ_THRESH     = 1
) (
  input  logic                         Clock,
  input  logic                         Clear_n,
  input  logic                         Strobe,
  input  logic [DATA_WIDTH_IN-1:0]     Input,
  input  logic                         Rd,
  input  logic                         OvrClr,
  output logic [DATA_WIDTH_OUT-1:0]    BusMuxIn,
  output logic                         Empty,
  output logic                         Full,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Overrun,
  output logic                         Irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH_IN-1:0] mem [DEPTH];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            count, count_nxt;
  logic                     strb_q, ovr_q;
  logic                     cap, push, pop, drop;
  logic [DATA_WIDTH_IN-1:0] head;
  logic [DATA_WIDTH_OUT-1:0] head_ext;

  assign Empty = (count == '0);
  assign Full  = (count == CW'(DEPTH));
  assign Count = count;
  assign Overrun = ovr_q;

  assign cap  = STROBE_EDGE ? (Strobe & ~strb_q) : Strobe;
  assign pop  = Rd & ~Empty;
  // a pop in the same cycle frees the slot the push needs
  assign push = cap & (~Full | pop);
  assign drop = cap & Full & ~pop;
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge Clock) begin
    if (!Clear_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      strb_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      strb_q <= Strobe;
      count  <= count_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop)        ovr_q <= 1'b1;
      else if (OvrClr) ovr_q <= 1'b0;
    end
  end

  // storage carries no reset; a push during Clear_n is discarded
  always_ff @(posedge Clock) begin
    if (Clear_n && push) mem[wr_ptr] <= Input;
  end

  assign head = mem[rd_ptr];

  generate
    if (DATA_WIDTH_OUT > DATA_WIDTH_IN) begin : g_wide
      if (SIGN_EXT) begin : g_sx
        assign head_ext = {{(DATA_WIDTH_OUT-DATA_WIDTH_IN){head[DATA_WIDTH_IN-1]}}, head};
      end else begin : g_zx
        assign head_ext = {{(DATA_WIDTH_OUT-DATA_WIDTH_IN){1'b0}}, head};
      end
    end else begin : g_narrow
      assign head_ext = head[DATA_WIDTH_OUT-1:0];
    end
  endgenerate

  assign BusMuxIn = Empty ? '0 : head_ext;

`ifdef INPORT_FIFO_IRQ_EN
  logic irq_q;
  always_ff @(posedge Clock) begin
    if (!Clear_n) irq_q <= 1'b0;
    else          irq_q <= (count_nxt >= CW'(IRQ_THRESH));
  end
  assign Irq = irq_q;
`else
  assign Irq = 1'b0;
`endif

endmodule

// File: tb/tb_inport_fifo.sv
// Randomized and directed checks of inport_fifo against a queue-based reference model.
module tb_inport_fifo;
  logic        Clock = 1'b0;
  logic        Clear_n = 1'b0, Strobe = 1'b0, Rd = 1'b0, OvrClr = 1'b0;
  logic [31:0] Input = '0;
  logic [31:0] BusMuxIn;
  logic        Empty, Full, Overrun, Irq;
  logic [2:0]  Count;

  // auxiliary instances: level strobe with sign extension, edge strobe with zero extension
  logic        s_l = 1'b0, s_z = 1'b0;
  logic [7:0]  d_l = '0, d_z = '0;
  logic [31:0] bus_l, bus_z;
  logic        emp_l, full_l, ovr_l, irq_l, emp_z, full_z, ovr_z, irq_z;
  logic [2:0]  cnt_l, cnt_z;

  int total = 0, bad = 0;
  logic [31:0] q[$];
  bit prev = 0, ovr = 0;

  always #5 Clock = ~Clock;

  inport_fifo #(.DATA_WIDTH_IN(32), .DATA_WIDTH_OUT(32), .DEPTH(4), .STROBE_EDGE(1'b1),
                .SIGN_EXT(1'b0), .IRQ_THRESH(2)) dut (
    .Clock(Clock), .Clear_n(Clear_n), .Strobe(Strobe), .Input(Input), .Rd(Rd), .OvrClr(OvrClr),
    .BusMuxIn(BusMuxIn), .Empty(Empty), .Full(Full), .Count(Count), .Overrun(Overrun), .Irq(Irq));

  inport_fifo #(.DATA_WIDTH_IN(8), .DATA_WIDTH_OUT(32), .DEPTH(4), .STROBE_EDGE(1'b0),
                .SIGN_EXT(1'b1), .IRQ_THRESH(1)) dut_l (
    .Clock(Clock), .Clear_n(Clear_n), .Strobe(s_l), .Input(d_l), .Rd(1'b0), .OvrClr(1'b0),
    .BusMuxIn(bus_l), .Empty(emp_l), .Full(full_l), .Count(cnt_l), .Overrun(ovr_l), .Irq(irq_l));

  inport_fifo #(.DATA_WIDTH_IN(8), .DATA_WIDTH_OUT(32), .DEPTH(4), .STROBE_EDGE(1'b1),
                .SIGN_EXT(1'b0), .IRQ_THRESH(1)) dut_z (
    .Clock(Clock), .Clear_n(Clear_n), .Strobe(s_z), .Input(d_z), .Rd(1'b0), .OvrClr(1'b0),
    .BusMuxIn(bus_z), .Empty(emp_z), .Full(full_z), .Count(cnt_z), .Overrun(ovr_z), .Irq(irq_z));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: drive at negedge, advance the model at posedge, compare 1 time unit later
  task automatic cyc(input bit s, input logic [31:0] d, input bit r, input bit oc, input bit clr);
    bit cap, pop, full;
    logic [31:0] head;
    int n;
    @(negedge Clock);
    Strobe = s; Input = d; Rd = r; OvrClr = oc; Clear_n = clr;
    @(posedge Clock);
    if (!clr) begin
      q.delete(); prev = 0; ovr = 0;
    end else begin
      cap  = s && !prev;
      full = (q.size() == 4);
      pop  = r && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (oc) ovr = 0;
      if (cap) begin
        if (!full || pop) q.push_back(d);
        else ovr = 1;
      end
      prev = s;
    end
    #1;
    n = q.size();
    head = (n > 0) ? q[0] : 32'h0;
    check("bus",   BusMuxIn, head);
    check("count", {29'b0, Count}, n);
    check("empty", {31'b0, Empty}, {31'b0, n == 0});
    check("full",  {31'b0, Full},  {31'b0, n == 4});
    check("ovr",   {31'b0, Overrun}, {31'b0, ovr});
`ifdef INPORT_FIFO_IRQ_EN
    check("irq",   {31'b0, Irq}, {31'b0, n >= 2});
`else
    check("irq",   {31'b0, Irq}, 32'h0);
`endif
  endtask

  initial begin
    // reset with strobe toggling
    cyc(1, 32'hAA, 0, 0, 0);
    cyc(0, 32'hBB, 0, 0, 0);
    check("rst_l_bus", bus_l, 32'h0);
    check("rst_l_cnt", {29'b0, cnt_l}, 32'h0);

    // fill with four pulses, then drain
    cyc(1, 32'h11, 0, 0, 1); cyc(0, 0, 0, 0, 1);
    cyc(1, 32'h22, 0, 0, 1); cyc(0, 0, 0, 0, 1);
    cyc(1, 32'h33, 0, 0, 1); cyc(0, 0, 0, 0, 1);
    cyc(1, 32'h44, 0, 0, 1); cyc(0, 0, 0, 0, 1);
    check("full_head", BusMuxIn, 32'h11);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, 1); cyc(0, 0, 0, 0, 1);
    end
    check("drained_bus", BusMuxIn, 32'h0);

    // refill, drop, clear, then drop and clear together
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 32'h100 + i, 0, 0, 1); cyc(0, 0, 0, 0, 1);
    end
    cyc(1, 32'h55, 0, 0, 1); cyc(0, 0, 0, 0, 1);
    check("drop_ovr", {31'b0, Overrun}, 32'h1);
    cyc(0, 0, 0, 1, 1);
    check("ovrclr", {31'b0, Overrun}, 32'h0);
    cyc(1, 32'h56, 0, 1, 1);
    check("set_wins", {31'b0, Overrun}, 32'h1);
    cyc(0, 0, 0, 1, 1);

    // full: pop and push in one cycle
    cyc(1, 32'h66, 1, 0, 1);
    check("fpp_head", BusMuxIn, 32'h102);
    cyc(0, 0, 1, 0, 1); cyc(0, 0, 1, 0, 1); cyc(0, 0, 1, 0, 1);
    check("fpp_tail", BusMuxIn, 32'h66);
    cyc(0, 0, 1, 0, 1);
    // empty: pop ignored, push lands
    cyc(1, 32'h77, 1, 0, 1);
    check("epp_bus", BusMuxIn, 32'h77);
    check("epp_cnt", {29'b0, Count}, 32'h1);
    cyc(0, 0, 0, 0, 1);

    // held strobe: edge mode pushes once
    for (int i = 0; i < 5; i++) cyc(1, 32'h200 + i, 0, 0, 1);
    check("held_cnt", {29'b0, Count}, 32'h2);
    cyc(0, 0, 0, 0, 1);

    // level-mode instance with sign extension, edge-mode instance with zero extension
    s_l = 1'b1; d_l = 8'h80; s_z = 1'b1; d_z = 8'h80;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 1);
      check("lvl_cnt", {29'b0, cnt_l}, (i < 4) ? i + 1 : 4);
      check("lvl_ovr", {31'b0, ovr_l}, {31'b0, i == 4});
    end
    check("sext", bus_l, 32'hFFFF_FF80);
    check("zext", bus_z, 32'h0000_0080);
    check("edge_cnt", {29'b0, cnt_z}, 32'h1);
    s_l = 1'b0; s_z = 1'b0;

    // random traffic with occasional reset
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) != 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
